amba_ahb_sram_slave: RTL and testbench

//  AHB-lite SRAM slave: byte-addressable memory with programmable wait states, endian lane

---
 rtl/amba_ahb_sram_slave.sv | 176 +++++++++++++++++
 tb/tb_amba_ahb_sram_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/amba_ahb_sram_slave.sv
// AHB-lite SRAM slave: byte-addressable memory with per-transfer-type wait states and two-cycle ERROR.
// Latency: address phase registered at accept; data phase completes after LW_*/LR_* wait cycles.
// Backpressure: hreadyout low during wait states and ERR1; optional write protection via AHB_SLV_PROT_EN.
module amba_ahb_sram_slave #(
  parameter int    AW    = 32,
  parameter int    DW    = 32,
  parameter string DE    = "LITTLE",
  parameter int    MS    = 4096,
  parameter int    LW_NS = 0,
  parameter int    LW_S  = 0,
  parameter int    LR_NS = 0,
  parameter int    LR_S  = 0,
  parameter int    PB    = MS / 2
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic [DW-1:0] hwdata,
  input  logic          hreadyin,
  input  logic          error,
  output logic [DW-1:0] hrdata,
  output logic          hreadyout,
  output logic          hresp
);

  localparam int SW  = DW / 8;
  localparam int SWB = $clog2(SW);
  localparam int MAW = $clog2(MS);
  localparam bit BIG = (DE == "BIG");

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t           state, nxt;
  logic [7:0]       mem [MS];

  // Registered data-phase context of the transfer currently in flight
  logic             dp_vld;
  logic             dp_err;
  logic             dp_wr;
  logic [2:0]       dp_size;
  logic [MAW-1:0]   dp_addr;
  logic [7:0]       cnt;

  logic             acc, rdy_st, take;
  logic [7:0]       sz_bytes;
  logic [6:0]       amask;
  logic             chk_oob, chk_size, chk_align, chk_prot, acc_err;
  logic [7:0]       delay;
  logic [SW-1:0]    lane_en;
  logic [7:0]       off8, szb8;
  logic [MAW-1:0]   base;
  logic             commit;

  // hburst is accepted but carries no meaning for a flat memory
  logic             unused_in;
  assign unused_in = ^{hburst, hprot};

  assign acc    = hsel & hreadyin & htrans[1];
  assign rdy_st = (state == S_IDLE) | (state == S_ERR2);
  // A new address phase is only meaningful while this slave is presenting ready
  assign take   = acc & rdy_st;

  // Address-phase legality checks
  always_comb begin
    sz_bytes  = 8'd1 << hsize;
    amask     = 7'(sz_bytes - 8'd1);
    chk_oob   = 64'(haddr) >= 64'(MS);
    chk_size  = sz_bytes > 8'(SW);
    chk_align = |(haddr[6:0] & amask);
`ifdef AHB_SLV_PROT_EN
    chk_prot  = hwrite & ~hprot[1] & (64'(haddr) >= 64'(PB));
`else
    chk_prot  = 1'b0;
`endif
    acc_err   = error | chk_oob | chk_size | chk_align | chk_prot;
    if (htrans[0]) delay = hwrite ? 8'(LW_S) : 8'(LR_S);
    else           delay = hwrite ? 8'(LW_NS) : 8'(LR_NS);
  end

  // State register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= S_IDLE;
    else          state <= nxt;
  end

  // Next-state: wait states first, then either completion or the two ERROR cycles
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_ERR2: begin
        if (take) begin
          if (delay != 8'd0) nxt = S_WAIT;
          else if (acc_err)  nxt = S_ERR1;
          else               nxt = S_IDLE;
        end else begin
          nxt = S_IDLE;
        end
      end
      S_WAIT:  if (cnt == 8'd0) nxt = dp_err ? S_ERR1 : S_IDLE;
      S_ERR1:  nxt = S_ERR2;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      S_WAIT:  begin hreadyout = 1'b0; hresp = 1'b0; end
      S_ERR1:  begin hreadyout = 1'b0; hresp = 1'b1; end
      S_ERR2:  begin hreadyout = 1'b1; hresp = 1'b1; end
      default: begin hreadyout = 1'b1; hresp = 1'b0; end
    endcase
  end

  // Capture address phase; counter holds remaining wait cycles minus one
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_vld  <= 1'b0;
      dp_err  <= 1'b0;
      dp_wr   <= 1'b0;
      dp_size <= 3'd0;
      dp_addr <= '0;
      cnt     <= 8'd0;
    end else if (take) begin
      dp_vld  <= 1'b1;
      dp_err  <= acc_err;
      dp_wr   <= hwrite;
      dp_size <= hsize;
      dp_addr <= haddr[MAW-1:0];
      cnt     <= (delay == 8'd0) ? 8'd0 : delay - 8'd1;
    end else if (rdy_st) begin
      dp_vld  <= 1'b0;
    end else if (state == S_WAIT && cnt != 8'd0) begin
      cnt     <= cnt - 8'd1;
    end
  end

  // Active byte lanes of the in-flight transfer; completion always lands in IDLE
  always_comb begin
    lane_en = '0;
    off8    = 8'(dp_addr[SWB-1:0]);
    szb8    = 8'd1 << dp_size;
    base    = {dp_addr[MAW-1:SWB], {SWB{1'b0}}};
    commit  = (state == S_IDLE) & dp_vld & ~dp_err;
    for (int k = 0; k < SW; k++)
      lane_en[k] = (8'(k) >= off8) && (8'(k) < off8 + szb8);
  end

  // Memory write on the completing edge; contents deliberately not reset
  always_ff @(posedge hclk) begin
    if (commit && dp_wr) begin
      for (int k = 0; k < SW; k++)
        if (lane_en[k])
          mem[base + MAW'(k)] <= hwdata[8*(BIG ? (SW-1-k) : k) +: 8];
    end
  end

  // Read data only on active lanes of a completing read, zero everywhere else
  always_comb begin
    hrdata = '0;
    if (commit && !dp_wr) begin
      for (int k = 0; k < SW; k++)
        if (lane_en[k])
          hrdata[8*(BIG ? (SW-1-k) : k) +: 8] = mem[base + MAW'(k)];
    end
  end

endmodule

// File: tb/tb_amba_ahb_sram_slave.sv
// Bench for amba_ahb_sram_slave: little-endian instance with distinct wait states,
// plus a zero-wait big-endian instance; table of single transfers and a few pipelined sequences.
module tb_amba_ahb_sram_slave;

`ifdef AHB_SLV_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel, hsel_b;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        error;
  logic [31:0] hrdata, hrdata_b;
  logic        hreadyout, hreadyout_b;
  logic        hresp, hresp_b;
  logic        hreadyin, hreadyin_b;

  int checks = 0;
  int failures = 0;

  assign hreadyin   = hreadyout;
  assign hreadyin_b = hreadyout_b;

  always #5 hclk = ~hclk;

  amba_ahb_sram_slave #(
    .AW(32), .DW(32), .DE("LITTLE"), .MS(4096),
    .LW_NS(2), .LW_S(1), .LR_NS(3), .LR_S(0), .PB(2048)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hreadyin(hreadyin), .error(error), .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
  );

  amba_ahb_sram_slave #(
    .AW(32), .DW(32), .DE("BIG"), .MS(4096),
    .LW_NS(0), .LW_S(0), .LR_NS(0), .LR_S(0), .PB(2048)
  ) dut_b (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hreadyin(hreadyin_b), .error(error), .hrdata(hrdata_b), .hreadyout(hreadyout_b), .hresp(hresp_b)
  );

  typedef struct {
    bit          big;
    bit          wr;
    bit          seq;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [3:0]  prot;
    int          exp_waits;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit big, bit wr, bit seq, logic [2:0] size, logic [31:0] addr,
                              logic [31:0] wdata, bit err, logic [3:0] prot,
                              int w, bit e, logic [31:0] rd);
    vec_t v;
    v.big = big; v.wr = wr; v.seq = seq; v.size = size; v.addr = addr; v.wdata = wdata;
    v.err = err; v.prot = prot; v.exp_waits = w; v.exp_err = e; v.exp_rd = rd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    hsel = 1'b0; hsel_b = 1'b0; htrans = 2'b00; hwrite = 1'b0; error = 1'b0;
  endtask

  // One isolated transfer: address phase, then observe the data phase until ready
  task automatic do_xfer(input vec_t v, input string nm);
    int          waits, e1, n;
    bit          done;
    logic        rdy, rsp;
    logic [31:0] rd;
    if (v.big) hsel_b = 1'b1; else hsel = 1'b1;
    haddr = v.addr; htrans = v.seq ? 2'b11 : 2'b10; hwrite = v.wr; hsize = v.size;
    error = v.err; hprot = v.prot;
    @(posedge hclk); #1;
    idle_bus();
    hwdata = v.wdata;
    waits = 0; e1 = 0; n = 0; done = 1'b0; rsp = 1'b0; rd = '0;
    while (!done && n < 300) begin
      @(negedge hclk);
      rdy = v.big ? hreadyout_b : hreadyout;
      rsp = v.big ? hresp_b : hresp;
      rd  = v.big ? hrdata_b : hrdata;
      if (rdy) done = 1'b1;
      else if (rsp) e1++;
      else waits++;
      n++;
      @(posedge hclk); #1;
    end
    check({nm, ".done"}, 32'(done), 32'd1);
    check({nm, ".waits"}, 32'(waits), 32'(v.exp_waits));
    check({nm, ".err1"}, 32'(e1), v.exp_err ? 32'd1 : 32'd0);
    check({nm, ".resp"}, 32'(rsp), 32'(v.exp_err));
    check({nm, ".rdata"}, rd, v.exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    hresetn = 1'b0;
    idle_bus();
    haddr = '0; hsize = 3'd2; hburst = 3'd0; hprot = 4'd0; hwdata = '0;
    repeat (2) @(negedge hclk);
    check("rst.ready", 32'(hreadyout), 32'd1);
    check("rst.resp", 32'(hresp), 32'd0);
    check("rst.rdata", hrdata, 32'd0);
    check("rst_b.ready", 32'(hreadyout_b), 32'd1);
    check("rst_b.resp", 32'(hresp_b), 32'd0);
    check("rst_b.rdata", hrdata_b, 32'd0);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    //          big wr seq size addr        wdata         err prot    waits err rdata
    vt.push_back(mk(0, 1, 0, 3'd2, 32'h020, 32'hDEADBEEF, 0, 4'b0000, 2, 0, 32'h0));
    vt.push_back(mk(0, 0, 0, 3'd2, 32'h020, 32'h0,        0, 4'b0000, 3, 0, 32'hDEADBEEF));
    vt.push_back(mk(0, 1, 1, 3'd0, 32'h023, 32'hAA112233, 0, 4'b0000, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 1, 3'd2, 32'h020, 32'h0,        0, 4'b0000, 0, 0, 32'hAAADBEEF));
    vt.push_back(mk(0, 0, 1, 3'd0, 32'h022, 32'h0,        0, 4'b0000, 0, 0, 32'h00AD0000));
    vt.push_back(mk(0, 0, 1, 3'd1, 32'h022, 32'h0,        0, 4'b0000, 0, 0, 32'hAAAD0000));
    vt.push_back(mk(0, 0, 0, 3'd2, 32'h1000, 32'h0,       0, 4'b0000, 3, 1, 32'h0));
    vt.push_back(mk(0, 1, 1, 3'd1, 32'h021, 32'h55555555, 0, 4'b0000, 1, 1, 32'h0));
    vt.push_back(mk(0, 1, 1, 3'd2, 32'h020, 32'h0,        1, 4'b0000, 1, 1, 32'h0));
    vt.push_back(mk(0, 0, 1, 3'd2, 32'h020, 32'h0,        0, 4'b0000, 0, 0, 32'hAAADBEEF));
    vt.push_back(mk(0, 0, 1, 3'd3, 32'h028, 32'h0,        0, 4'b0000, 0, 1, 32'h0));
    vt.push_back(mk(0, 0, 1, 3'd2, 32'h020, 32'h0,        1, 4'b0000, 0, 1, 32'h0));
    vt.push_back(mk(0, 1, 1, 3'd1, 32'h032, 32'hBEEF0000, 0, 4'b0000, 1, 0, 32'h0));
    vt.push_back(mk(0, 1, 1, 3'd0, 32'h030, 32'h00000011, 0, 4'b0000, 1, 0, 32'h0));
    vt.push_back(mk(0, 1, 1, 3'd0, 32'h031, 32'h00002200, 0, 4'b0000, 1, 0, 32'h0));
    vt.push_back(mk(0, 0, 0, 3'd2, 32'h030, 32'h0,        0, 4'b0000, 3, 0, 32'hBEEF2211));
    vt.push_back(mk(0, 1, 0, 3'd2, 32'h800, 32'hCAFEF00D, 0, 4'b0010, 2, 0, 32'h0));
    vt.push_back(mk(0, 1, 0, 3'd2, 32'h800, 32'h11112222, 0, 4'b0000, 2, PROT, 32'h0));
    vt.push_back(mk(0, 0, 1, 3'd2, 32'h800, 32'h0,        0, 4'b0000, 0, 0,
                    PROT ? 32'hCAFEF00D : 32'h11112222));
    vt.push_back(mk(1, 1, 0, 3'd2, 32'h020, 32'hDEADBEEF, 0, 4'b0000, 0, 0, 32'h0));
    vt.push_back(mk(1, 1, 1, 3'd0, 32'h023, 32'h000000AA, 0, 4'b0000, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 3'd2, 32'h020, 32'h0,        0, 4'b0000, 0, 0, 32'hDEADBEAA));
    vt.push_back(mk(1, 0, 1, 3'd0, 32'h023, 32'h0,        0, 4'b0000, 0, 0, 32'h000000AA));
    vt.push_back(mk(1, 0, 1, 3'd0, 32'h020, 32'h0,        0, 4'b0000, 0, 0, 32'hDE000000));

    for (int i = 0; i < vt.size(); i++)
      do_xfer(vt[i], $sformatf("v%0d", i));

    // Zero-wait write immediately followed by a read of the same word (big-endian instance)
    hsel_b = 1'b1; haddr = 32'h40; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hwdata = 32'h12345678; htrans = 2'b11; hwrite = 1'b0;
    @(negedge hclk);
    check("b2b.wr_ready", 32'(hreadyout_b), 32'd1);
    @(posedge hclk); #1;
    idle_bus();
    @(negedge hclk);
    check("b2b.rd_ready", 32'(hreadyout_b), 32'd1);
    check("b2b.rd_resp", 32'(hresp_b), 32'd0);
    check("b2b.rdata", hrdata_b, 32'h12345678);
    @(posedge hclk); #1;

    // Out-of-range zero-wait read, then a new transfer accepted during ERR2
    hsel = 1'b1; haddr = 32'h2000; htrans = 2'b11; hwrite = 1'b0; hsize = 3'd2;
    @(posedge hclk); #1;
    idle_bus();
    @(negedge hclk);
    check("err2acc.e1_ready", 32'(hreadyout), 32'd0);
    check("err2acc.e1_resp", 32'(hresp), 32'd1);
    @(posedge hclk); #1;
    hsel = 1'b1; haddr = 32'h20; htrans = 2'b11; hwrite = 1'b0; hsize = 3'd2;
    @(negedge hclk);
    check("err2acc.e2_ready", 32'(hreadyout), 32'd1);
    check("err2acc.e2_resp", 32'(hresp), 32'd1);
    @(posedge hclk); #1;
    idle_bus();
    @(negedge hclk);
    check("err2acc.ready", 32'(hreadyout), 32'd1);
    check("err2acc.resp", 32'(hresp), 32'd0);
    check("err2acc.rdata", hrdata, 32'hAAADBEEF);
    @(posedge hclk); #1;

    // Reset pulse while a NONSEQ read sits in its wait states
    hsel = 1'b1; haddr = 32'h10; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    @(posedge hclk); #1;
    idle_bus();
    @(negedge hclk);
    check("rstwait.in_wait", 32'(hreadyout), 32'd0);
    hresetn = 1'b0;
    #1;
    check("rstwait.ready", 32'(hreadyout), 32'd1);
    check("rstwait.resp", 32'(hresp), 32'd0);
    check("rstwait.rdata", hrdata, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    check("rstwait.after_ready", 32'(hreadyout), 32'd1);
    check("rstwait.after_rdata", hrdata, 32'd0);
    @(posedge hclk); #1;
    do_xfer(mk(0, 0, 0, 3'd2, 32'h020, 32'h0, 0, 4'b0000, 3, 0, 32'hAAADBEEF), "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
